// File: rtl/memwrite_checker_pkg.sv
// Shared types for the data-memory write checker: FSM state encoding and
// the status codes reported on the status output.
package memwrite_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_IDLE = 2'b00;
  localparam logic [1:0] STATUS_PASS = 2'b01;
  localparam logic [1:0] STATUS_MISM = 2'b10;
  localparam logic [1:0] STATUS_TOUT = 2'b11;

endpackage

// File: rtl/memwrite_exp_table.sv
// Expected-write table: DEPTH entries of {address, data}, one synchronous
// write port and one combinational read port. Contents are never reset.
module memwrite_exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]        rd_addr_o,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_addr_o = addr_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/memwrite_checker.sv
// Monitors the processor's data-memory write port against a preloaded list of
// expected writes and reports a registered pass / mismatch / timeout verdict.
module memwrite_checker
  import memwrite_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [$clog2(DEPTH)-1:0]     load_idx,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [DATA_W-1:0]            load_data,
  input  logic [$clog2(DEPTH):0]       num_exp,
  input  logic                         strict,
  input  logic                         start,
  input  logic                         MemWrite,
  input  logic [ADDR_W-1:0]            DataAdr,
  input  logic [DATA_W-1:0]            WriteData,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   status,
  output logic [$clog2(DEPTH):0]       match_cnt,
  output logic [7:0]                   skip_cnt,
  output logic [ADDR_W-1:0]            fail_adr,
  output logic [DATA_W-1:0]            fail_wdata,
  output logic [$clog2(TIMEOUT+1)-1:0] cycles,
  output state_e                       dbg_state
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     match_q, match_d;
  logic [CW-1:0]     nexp_q, nexp_d;
  logic              strict_q, strict_d;
  logic [7:0]        skip_q, skip_d;
  logic [TW-1:0]     cycles_q, cycles_d;
  logic [ADDR_W-1:0] fadr_q, fadr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              running, arm, hit, last_cycle;
  logic [CW-1:0]     nexp_clamped, match_inc;

  memwrite_exp_table #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk      (clk),
    .we_i     (load_en && !running),
    .wr_idx_i (load_idx),
    .wr_addr_i(load_addr),
    .wr_data_i(load_data),
    .rd_idx_i (ptr_q),
    .rd_addr_o(exp_addr),
    .rd_data_o(exp_data)
  );

  assign running      = (state_q == S_RUN);
  assign arm          = start && !running;
  assign hit          = (DataAdr == exp_addr) && (WriteData == exp_data);
  assign last_cycle   = (cycles_q == TW'(TIMEOUT - 1));
  assign match_inc    = match_q + CW'(1);
  assign nexp_clamped = (num_exp > CW'(DEPTH)) ? CW'(DEPTH) : num_exp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write evaluation takes priority over the timeout on the final RUN cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (MemWrite && hit && (match_inc == nexp_q)) state_d = S_PASS;
        else if (MemWrite && !hit && strict_q)        state_d = S_FAIL;
        else if (last_cycle)                           state_d = S_TOUT;
      end
      default: begin
        if (start) state_d = (nexp_clamped == '0) ? S_PASS : S_RUN;
      end
    endcase
  end

  always_comb begin
    busy   = running;
    done   = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TOUT);
    pass   = (state_q == S_PASS);
    status = STATUS_IDLE;
    unique case (state_q)
      S_PASS:  status = STATUS_PASS;
      S_FAIL:  status = STATUS_MISM;
      S_TOUT:  status = STATUS_TOUT;
      default: status = STATUS_IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    match_d  = match_q;
    nexp_d   = nexp_q;
    strict_d = strict_q;
    skip_d   = skip_q;
    cycles_d = cycles_q;
    fadr_d   = fadr_q;
    fdata_d  = fdata_q;
    if (arm) begin
      nexp_d   = nexp_clamped;
      strict_d = strict;
      ptr_d    = '0;
      match_d  = '0;
      skip_d   = '0;
      cycles_d = '0;
      fadr_d   = '0;
      fdata_d  = '0;
    end else if (running) begin
      cycles_d = cycles_q + TW'(1);
      if (MemWrite) begin
        if (hit) begin
          ptr_d   = ptr_q + IW'(1);
          match_d = match_inc;
        end else if (strict_q) begin
          fadr_d  = DataAdr;
          fdata_d = WriteData;
        end else if (skip_q != 8'hFF) begin
          skip_d = skip_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      match_q  <= '0;
      nexp_q   <= '0;
      strict_q <= 1'b0;
      skip_q   <= '0;
      cycles_q <= '0;
      fadr_q   <= '0;
      fdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      match_q  <= match_d;
      nexp_q   <= nexp_d;
      strict_q <= strict_d;
      skip_q   <= skip_d;
      cycles_q <= cycles_d;
      fadr_q   <= fadr_d;
      fdata_q  <= fdata_d;
    end
  end

  assign match_cnt  = match_q;
  assign skip_cnt   = skip_q;
  assign fail_adr   = fadr_q;
  assign fail_wdata = fdata_q;
  assign cycles     = cycles_q;
  assign dbg_state  = state_q;

endmodule
